// File: rtl/div_ctrl_if.sv
// Bundle between the MIX DIV sequencer, the instruction unit driving it and the
// radix-8 magnitude divider it launches. The slave side is div_ctrl itself.
interface div_ctrl_if;
  logic        start;
  logic [30:0] ra_in;
  logic [30:0] rx_in;
  logic [30:0] v_in;
  logic        busy;
  logic        done;
  logic        wr;
  logic        ovf;
  logic [30:0] ra_out;
  logic [30:0] rx_out;
  logic        div_start;
  logic [29:0] div_a;
  logic [59:0] div_c;
  logic        div_stop;
  logic [29:0] div_b;
  logic [29:0] div_rest;

  modport slave (
    input  start, ra_in, rx_in, v_in, div_stop, div_b, div_rest,
    output busy, done, wr, ovf, ra_out, rx_out, div_start, div_a, div_c
  );

  modport master (
    output start, ra_in, rx_in, v_in, div_stop, div_b, div_rest,
    input  busy, done, wr, ovf, ra_out, rx_out, div_start, div_a, div_c
  );
endinterface

// File: rtl/div_ctrl.sv
// MIX DIV sequencer: overflow check, sign strip, divider launch, sign reapply.
// A post-reset holdoff lets any divider run orphaned by reset drain first.
module div_ctrl #(
  parameter int HOLDOFF = 12
) (
  input logic       clk,
  input logic       reset,
  div_ctrl_if.slave bus
);
  localparam int CW = $clog2(HOLDOFF) + 1;

  typedef enum logic [2:0] {HOLD, IDLE, CHECK, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sa_q, sa_d;
  logic          sv_q, sv_d;
  logic [29:0]   div_a_q, div_a_d;
  logic [59:0]   div_c_q, div_c_d;
  logic          div_start_q, div_start_d;
  logic          done_q, done_d;
  logic          wr_q, wr_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic [30:0]   ra_out_q, ra_out_d;
  logic [30:0]   rx_out_q, rx_out_d;

  // The rX sign never reaches the result.
  logic rx_sign_unused;
  assign rx_sign_unused = bus.rx_in[30];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sa_d        = sa_q;
    sv_d        = sv_q;
    div_a_d     = div_a_q;
    div_c_d     = div_c_q;
    div_start_d = 1'b0;
    done_d      = 1'b0;
    wr_d        = wr_q;
    ovf_d       = ovf_q;
    ra_out_d    = ra_out_q;
    rx_out_d    = rx_out_q;
    case (state_q)
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.ra_in[30];
          sv_d    = bus.v_in[30];
          div_a_d = bus.v_in[29:0];
          div_c_d = {bus.ra_in[29:0], bus.rx_in[29:0]};
          state_d = CHECK;
        end
      end
      CHECK: begin
        // High half >= divisor means the quotient cannot fit (covers |V| = 0).
        if (div_c_q[59:30] >= div_a_q) begin
          ovf_d   = 1'b1;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          div_start_d = 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus.div_stop) begin
          ra_out_d = {sa_q ^ sv_q, bus.div_b};
          rx_out_d = {sa_q, bus.div_rest};
          wr_d     = 1'b1;
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = HOLD;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= CW'(HOLDOFF - 1);
      sa_q        <= 1'b0;
      sv_q        <= 1'b0;
      div_a_q     <= '0;
      div_c_q     <= '0;
      div_start_q <= 1'b0;
      done_q      <= 1'b0;
      wr_q        <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b1;
      ra_out_q    <= '0;
      rx_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sa_q        <= sa_d;
      sv_q        <= sv_d;
      div_a_q     <= div_a_d;
      div_c_q     <= div_c_d;
      div_start_q <= div_start_d;
      done_q      <= done_d;
      wr_q        <= wr_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      ra_out_q    <= ra_out_d;
      rx_out_q    <= rx_out_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wr        = wr_q;
  assign bus.ovf       = ovf_q;
  assign bus.ra_out    = ra_out_q;
  assign bus.rx_out    = rx_out_q;
  assign bus.div_start = div_start_q;
  assign bus.div_a     = div_a_q;
  assign bus.div_c     = div_c_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider that answers
// DIV_LAT cycles after it samples div_start.
module tb_div_ctrl;
  localparam int HOLDOFF = 12;
  localparam int DIV_LAT = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_ctrl_if bus();
  div_ctrl #(.HOLDOFF(HOLDOFF)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int dstart_cnt = 0;
  int m_cnt = 0;
  logic stray = 1'b0;
  logic [29:0] m_b = '0;
  logic [29:0] m_r = '0;
  logic [59:0] m_q, m_rem;

  assign m_q   = bus.div_c / {30'd0, bus.div_a};
  assign m_rem = bus.div_c % {30'd0, bus.div_a};

  always @(posedge clk) begin
    if (bus.done)      done_cnt   <= done_cnt + 1;
    if (bus.div_start) dstart_cnt <= dstart_cnt + 1;
    if (bus.div_start) begin
      m_cnt <= DIV_LAT;
      m_b   <= m_q[29:0];
      m_r   <= m_rem[29:0];
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign bus.div_stop = (m_cnt == 1) || stray;
  assign bus.div_b    = m_b;
  assign bus.div_rest = m_r;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles after reset; pokes start (and optionally div_stop) on the 3rd.
  task automatic hold_window(input bit poke_stop, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      bus.start = (n == 3);
      stray     = poke_stop && (n == 3);
      tick;
    end
    bus.start = 1'b0;
    stray     = 1'b0;
  endtask

  task automatic do_op(input logic [30:0] ra, input logic [30:0] rx, input logic [30:0] v,
                       input bit poke, output int lat);
    bus.ra_in = ra;
    bus.rx_in = rx;
    bus.v_in  = v;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      bus.start = poke && (lat == 5);
      tick;
      lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic op_chk(input string tag, input int lat, input int exp_lat,
                        input logic [30:0] ra, input logic [30:0] rx,
                        input logic wr, input logic ovf);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".wr"},  {63'd0, bus.wr},  {63'd0, wr});
    chk({tag, ".ovf"}, {63'd0, bus.ovf}, {63'd0, ovf});
    chk({tag, ".ra"},  {33'd0, bus.ra_out}, {33'd0, ra});
    chk({tag, ".rx"},  {33'd0, bus.rx_out}, {33'd0, rx});
    tick;
    chk({tag, ".done_1cyc"}, {63'd0, bus.done}, 64'd0);
    chk({tag, ".idle"},      {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int n, lat, dc, ds;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.ra_in = '0;
    bus.rx_in = '0;
    bus.v_in  = '0;
    tick;
    tick;
    chk("rst.busy",      {63'd0, bus.busy},      64'd1);
    chk("rst.done",      {63'd0, bus.done},      64'd0);
    chk("rst.wr",        {63'd0, bus.wr},        64'd0);
    chk("rst.ovf",       {63'd0, bus.ovf},       64'd0);
    chk("rst.div_start", {63'd0, bus.div_start}, 64'd0);
    chk("rst.ra",        {33'd0, bus.ra_out},    64'd0);
    chk("rst.rx",        {33'd0, bus.rx_out},    64'd0);
    reset = 1'b0;
    hold_window(1'b0, n);
    chk("hold.len", 64'(n), 64'(HOLDOFF));
    tick;
    chk("hold.no_done", 64'(done_cnt), 64'd0);

    // basic divide: 100 / 7 = 14 r 2
    do_op({1'b0, 30'd0}, {1'b0, 30'd100}, {1'b0, 30'd7}, 1'b0, lat);
    op_chk("basic", lat, 14, {1'b0, 30'd14}, {1'b0, 30'd2}, 1'b1, 1'b0);
    chk("basic.div_start", 64'(dstart_cnt), 64'd1);
    chk("basic.done_cnt",  64'(done_cnt),   64'd1);

    // minus-zero rA; start pulsed in WAIT must be dropped
    do_op({1'b1, 30'd0}, {1'b0, 30'd100}, {1'b0, 30'd7}, 1'b1, lat);
    op_chk("neg", lat, 14, {1'b1, 30'd14}, {1'b1, 30'd2}, 1'b1, 1'b0);
    tick;
    tick;
    chk("neg.one_done", 64'(done_cnt), 64'd2);
    chk("neg.busy_ign", {63'd0, bus.busy}, 64'd0);

    // back-to-back: 2^30 / 2 with minus divisor
    do_op({1'b0, 30'd1}, {1'b0, 30'd0}, {1'b1, 30'd2}, 1'b0, lat);
    op_chk("b2b", lat, 14, {1'b1, 30'd536870912}, {1'b0, 30'd0}, 1'b1, 1'b0);
    do_op({1'b0, 30'd1}, {1'b1, 30'd6}, {1'b0, 30'd4}, 1'b0, lat);
    op_chk("b2b2", lat, 14, {1'b0, 30'd268435457}, {1'b0, 30'd2}, 1'b1, 1'b0);
    ds = dstart_cnt;

    do_op({1'b0, 30'd5}, {1'b0, 30'd0}, {1'b0, 30'd5}, 1'b0, lat);
    op_chk("ovf", lat, 2, {1'b0, 30'd268435457}, {1'b0, 30'd2}, 1'b0, 1'b1);
    do_op({1'b0, 30'd0}, {1'b0, 30'd0}, {1'b0, 30'd0}, 1'b0, lat);
    op_chk("ovf0", lat, 2, {1'b0, 30'd268435457}, {1'b0, 30'd2}, 1'b0, 1'b1);
    chk("ovf.no_div_start", 64'(dstart_cnt), 64'(ds));

    // reset while in WAIT, divider keeps running, plus a stray stop
    dc = done_cnt;
    bus.ra_in = {1'b0, 30'd0};
    bus.rx_in = {1'b0, 30'd100};
    bus.v_in  = {1'b0, 30'd7};
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rwait.ra", {33'd0, bus.ra_out}, 64'd0);
    chk("rwait.rx", {33'd0, bus.rx_out}, 64'd0);
    hold_window(1'b1, n);
    chk("rwait.hold", 64'(n), 64'(HOLDOFF));
    tick;
    chk("rwait.no_done", 64'(done_cnt), 64'(dc));
    chk("rwait.ra_hold", {33'd0, bus.ra_out}, 64'd0);

    do_op({1'b0, 30'd0}, {1'b0, 30'd100}, {1'b0, 30'd7}, 1'b0, lat);
    op_chk("after", lat, 14, {1'b0, 30'd14}, {1'b0, 30'd2}, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer for the MIX DIV instruction, sitting directly upstream and downstream of the radix-8 magnitude divider. It takes sign-magnitude rA, rX and the memory operand V and performs the MIX overflow check. It then strips the signs and launches the divider with a one-cycle start pulse. When the divider's stop pulse arrives, it captures quotient and remainder, reapplies MIX sign rules and presents new rA/rX values with a one-cycle done strobe.

## Interface
- HOLDOFF, default 12: cycles after reset during which start is refused; must be at least the divider's worst-case start-to-stop span.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- ra_in, rx_in, v_in  in  31 each  MIX words, bit 30 = sign (1 = minus), [29:0] = magnitude.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion strobe.
- wr  out  1  valid with done; 1 = write ra_out/rx_out to registers.
- ovf  out  1  valid with done; 1 = set the overflow toggle.
- ra_out, rx_out  out  31 each  result words; hold value until the next done.
- div_start  out  1  to the divider start input.
- div_a  out  30  divisor magnitude, |V|.
- div_c  out  60  dividend magnitude, {rA[29:0], rX[29:0]}.
- div_stop  in  1  divider completion pulse.
- div_b, div_rest  in  30 each  quotient and remainder magnitudes.

## Operation
- States: HOLD, IDLE, CHECK, WAIT, DONE.
- Reset: state = HOLD, holdoff counter = HOLDOFF-1. done, wr, ovf and div_start = 0. ra_out and rx_out = 0.
- HOLD: the counter decrements each cycle, and the block moves to IDLE when it reaches 0. start and div_stop are ignored. This guarantees that a divider left running by a mid-operation reset has finished before the next launch.
- IDLE with start = 1:
  - latch sA = ra_in[30], sV = v_in[30], div_a = v_in[29:0], div_c = {ra_in[29:0], rx_in[29:0]};
  - go to CHECK.
- IDLE with start = 0: remain in IDLE; div_stop is ignored here.
- CHECK:
  - if div_c[59:30] >= div_a (this includes V magnitude 0): ovf_r = 1, wr_r = 0, leave ra_out/rx_out unchanged, go to DONE;
  - otherwise: div_start = 1 for exactly this next cycle, go to WAIT.
- WAIT:
  - div_start returns to 0;
  - on the cycle div_stop = 1, capture ra_out = {sA^sV, div_b} and rx_out = {sA, div_rest}, set wr_r = 1 and ovf_r = 0, go to DONE.
  - there is no timeout.
- DONE: done = 1, with wr = wr_r and ovf = ovf_r, for one cycle, then IDLE.
- Sign rules:
  - the result sign is applied even when the magnitude is zero, so minus zero is legal;
  - the sign of rx_in never affects the result;
  - the quotient fits in 30 bits because the overflow check passed.
- div_a and div_c stay stable from the IDLE latch until the next accepted start.
- start while busy is ignored and not queued.
- reset in any state aborts at once and returns to HOLD; a div_stop that later arrives from the aborted operation is ignored.

## Timing
- Start accepted at edge E0 → CHECK during E0–E1.
- Overflow path: done is high in cycle E1–E2, i.e. 2 cycles after start is sampled; div_start is never asserted.
- Normal path:
  - div_start is high in cycle E1–E2;
  - done is high in the cycle immediately after the cycle where div_stop = 1;
  - with the 10-step divider, done follows start by 14 cycles.
- ra_out, rx_out, wr and ovf change only at the edge that raises done.
- busy is high from E0 to the edge that ends done, so start may be re-asserted in the first cycle after done.

## Test plan
- Basic divide: after holdoff, ra_in = +0, rx_in = +100, v_in = +7 → done with wr = 1, ovf = 0, ra_out = +14, rx_out = +2; div_start is a single 1-cycle pulse.
- Sign rules: ra_in = −0, rx_in = +100, v_in = +7 → ra_out = −14, rx_out = −2. Then ra_in = +1, rx_in = +0, v_in = −2 → ra_out = −536870912, rx_out = +0.
- Overflow: ra_in = +5, rx_in = +0, v_in = +5 → done 2 cycles after start, ovf = 1, wr = 0, ra_out/rx_out unchanged, div_start stays 0. Repeat with v_in = +0 and ra_in = +0 → same response.
- Start refused while busy: start pulsed during WAIT and during the HOLD window → ignored; exactly one done per accepted start.
- Reset in WAIT: assert reset; a stray div_stop arrives 3 cycles later. Required: busy = 1 for HOLDOFF cycles, no done, outputs = 0, and the next operation completes correctly.
- Back-to-back: start re-asserted in the cycle after done → accepted, and the second result is correct.
